fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// fwd_scoreboard : in-flight destination tracker, operand forwarding and
//                  load-use stall detection; FWD_SCOREBOARD_STATS_EN adds counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_scoreboard #(
  parameter int DATA_SIZE        = 32,
  parameter int REG_ADDR         = 5,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic                        issue_is_load,
  input  logic [REG_ADDR-1:0]         issue_rd,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [STAGES*DATA_SIZE-1:0] stage_data,
  input  logic [REG_ADDR-1:0]         rs1_addr,
  input  logic [REG_ADDR-1:0]         rs2_addr,
  input  logic [DATA_SIZE-1:0]        rs1_data,
  input  logic [DATA_SIZE-1:0]        rs2_data,
  output logic [DATA_SIZE-1:0]        src1_data,
  output logic [DATA_SIZE-1:0]        src2_data,
  output logic                        load_use_stall,
  output logic [15:0]                 fwd_count,
  output logic [15:0]                 stall_count
);

  logic [STAGES-1:0]   r_valid;
  logic [STAGES-1:0]   r_is_load;
  logic [REG_ADDR-1:0] r_rd [STAGES];

  logic [STAGES-1:0]   w_writing;
  logic                w_hit1, w_hit2;
  logic                w_rdy1, w_rdy2;
  logic [DATA_SIZE-1:0] w_fwd1, w_fwd2;
  logic                w_accept;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_writing[k] = r_valid[k] && (r_rd[k] != '0);
    end
  end

  // Scan oldest to youngest so the youngest (lowest-index) match overwrites.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_writing[k] && (rs1_addr != '0) && (r_rd[k] == rs1_addr)) begin
        w_hit1 = 1'b1;
        w_rdy1 = !r_is_load[k] || (k >= LOAD_READY_STAGE);
        w_fwd1 = stage_data[k*DATA_SIZE +: DATA_SIZE];
      end
      if (w_writing[k] && (rs2_addr != '0) && (r_rd[k] == rs2_addr)) begin
        w_hit2 = 1'b1;
        w_rdy2 = !r_is_load[k] || (k >= LOAD_READY_STAGE);
        w_fwd2 = stage_data[k*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign src1_data      = (w_hit1 && w_rdy1) ? w_fwd1 : rs1_data;
  assign src2_data      = (w_hit2 && w_rdy2) ? w_fwd2 : rs2_data;
  assign load_use_stall = (w_hit1 && !w_rdy1) || (w_hit2 && !w_rdy2);
  assign w_accept       = !flush && !load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_is_load <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_rd[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_rd[k]      <= r_rd[k-1];
      end
      if (w_accept) begin
        r_valid[0]   <= issue_valid && issue_we;
        r_is_load[0] <= issue_is_load;
        r_rd[0]      <= issue_rd;
      end else begin
        r_valid[0]   <= 1'b0;
        r_is_load[0] <= 1'b0;
        r_rd[0]      <= '0;
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] r_fwd_count;
  logic [15:0] r_stall_count;
  logic        w_any_fwd;

  assign w_any_fwd = (w_hit1 && w_rdy1) || (w_hit2 && w_rdy2);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_count   <= '0;
      r_stall_count <= '0;
    end else if (!hold) begin
      if (w_any_fwd && (r_fwd_count != 16'hFFFF)) begin
        r_fwd_count <= r_fwd_count + 16'd1;
      end
      if (load_use_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign fwd_count   = r_fwd_count;
  assign stall_count = r_stall_count;
`else
  assign fwd_count   = 16'd0;
  assign stall_count = 16'd0;
`endif

endmodule

`default_nettype wire
